// File: rtl/mux_arbiter_2ch_if.sv
// Handshake/data bundle between two requesters, the arbiter
// and the shared downstream port.
interface mux_arbiter_2ch_if #(
  parameter int size = 32
);
  logic            req0_i;
  logic            req1_i;
  logic            last0_i;
  logic            last1_i;
  logic [size-1:0] data0_i;
  logic [size-1:0] data1_i;
  logic            ready_i;
  logic            valid_o;
  logic [size-1:0] data_o;
  logic            sel_o;
  logic            gnt0_o;
  logic            gnt1_o;
  logic            busy_o;

  modport master (
    output req0_i, req1_i, last0_i, last1_i,
    output data0_i, data1_i, ready_i,
    input  valid_o, data_o, sel_o,
    input  gnt0_o, gnt1_o, busy_o
  );

  modport slave (
    input  req0_i, req1_i, last0_i, last1_i,
    input  data0_i, data1_i, ready_i,
    output valid_o, data_o, sel_o,
    output gnt0_o, gnt1_o, busy_o
  );
endinterface

// File: rtl/mux_arbiter_2ch.sv
// Two-channel round-robin burst arbiter driving a shared 2:1 mux.
// Define ARB_BURST_LIMIT_EN to force release after MAX_BURST beats.
module mux_arbiter_2ch #(
  parameter int size      = 32,
  parameter int MAX_BURST = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  mux_arbiter_2ch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_e;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt0, gnt1;
  logic            valid;
  logic            xfer;
  logic            at_limit;
  logic            own_req;
  logic            own_last;
  logic            oth_req;
  logic [size-1:0] mux_data;

  assign gnt0  = (state_q == GRANT0);
  assign gnt1  = (state_q == GRANT1);
  assign valid = (gnt0 & bus.req0_i)
               | (gnt1 & bus.req1_i);
  assign xfer  = valid & bus.ready_i;

  assign own_req  = gnt1 ? bus.req1_i  : bus.req0_i;
  assign own_last = gnt1 ? bus.last1_i : bus.last0_i;
  assign oth_req  = gnt1 ? bus.req0_i  : bus.req1_i;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  assign at_limit = xfer & (cnt_q == CNT_LAST);
`else
  assign at_limit = 1'b0;
`endif

  assign mux_data = sel_q ? bus.data1_i : bus.data0_i;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_i && (!bus.req1_i || !prio_q)) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end else if (bus.req1_i) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if ((xfer && own_last) || !own_req || at_limit) begin
          prio_d = ~gnt1;
          if (oth_req) begin
            state_d = gnt1 ? GRANT0 : GRANT1;
            sel_d   = ~gnt1;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer && cnt_q != CNT_MAX) begin
          // saturate so the count never wraps when unlimited
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt0_o  = gnt0;
  assign bus.gnt1_o  = gnt1;
  assign bus.sel_o   = sel_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.valid_o = valid;
  assign bus.data_o  = mux_data;

endmodule

// File: tb/tb_mux_arbiter_2ch.sv
// Directed bench for mux_arbiter_2ch: reset, arbitration,
// handover, stall, burst limit and async reset mid-burst.
module tb_mux_arbiter_2ch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  mux_arbiter_2ch_if #(.size(32)) bus ();

  mux_arbiter_2ch #(
    .size      (32),
    .MAX_BURST (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req0_i  = 1'b0;
    bus.req1_i  = 1'b0;
    bus.last0_i = 1'b0;
    bus.last1_i = 1'b0;
    bus.ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gv();
    return {30'd0, bus.gnt1_o, bus.gnt0_o};
  endfunction

  logic       lastv [7] = '{0, 0, 1, 0, 1, 0, 1};
  logic [1:0] expg  [7] = '{0, 1, 1, 2, 2, 1, 1};
  logic       exps  [7] = '{0, 0, 0, 1, 1, 0, 0};

  initial begin
    logic [1:0] e;
    idle_in();
    bus.data0_i = 32'hAA;
    bus.data1_i = 32'hBB;

    // reset state
    @(negedge clk);
    chk("rst_gnt", gv(), 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data", bus.data_o, 32'hAA);

    // single beat on channel 0
    nxt();
    rst = 1'b0;
    bus.req0_i  = 1'b1;
    bus.data0_i = 32'h11;
    bus.last0_i = 1'b1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("t1_idle_gnt", gv(), 0);
    nxt();
    @(negedge clk);
    chk("t1_gnt", gv(), 1);
    chk("t1_sel", bus.sel_o, 0);
    chk("t1_valid", bus.valid_o, 1);
    chk("t1_data", bus.data_o, 32'h11);
    chk("t1_busy", bus.busy_o, 1);
    nxt();
    bus.req1_i  = 1'b1;
    bus.last1_i = 1'b1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", bus.busy_o, 0);
    nxt();
    @(negedge clk);
    chk("t1_prio_gnt", gv(), 2);
    chk("t1_prio_sel", bus.sel_o, 1);

    // round-robin 2-beat bursts, no bubble
    do_reset();
    bus.data0_i = 32'hA0;
    bus.data1_i = 32'hB0;
    bus.req0_i  = 1'b1;
    bus.req1_i  = 1'b1;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) nxt();
      bus.last0_i = lastv[c];
      bus.last1_i = lastv[c];
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", c), gv(), 32'(expg[c]));
      chk($sformatf("rr_sel%0d", c), bus.sel_o, 32'(exps[c]));
      chk($sformatf("rr_valid%0d", c), bus.valid_o, (c > 0) ? 1 : 0);
      if (c > 0)
        chk($sformatf("rr_data%0d", c), bus.data_o,
            exps[c] ? 32'hB0 : 32'hA0);
    end

    // stall during channel 1 burst
    do_reset();
    bus.data0_i = 32'hC0;
    bus.data1_i = 32'hD1;
    bus.req1_i  = 1'b1;
    nxt();
    bus.req0_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("st_gnt%0d", c), gv(), 2);
      chk($sformatf("st_data%0d", c), bus.data_o, 32'hD1);
      nxt();
    end
    bus.ready_i = 1'b1;
    bus.last1_i = 1'b1;
    @(negedge clk);
    chk("st_resume_gnt", gv(), 2);
    chk("st_resume_valid", bus.valid_o, 1);
    nxt();
    @(negedge clk);
    chk("st_handover", gv(), 1);

    // long stream on channel 0 against a waiting channel 1
    do_reset();
    bus.req0_i  = 1'b1;
    bus.req1_i  = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      nxt();
      @(negedge clk);
`ifdef ARB_BURST_LIMIT_EN
      e = (i <= 4) ? 2'd1 : 2'd2;
`else
      e = 2'd1;
`endif
      chk($sformatf("bl_gnt%0d", i), gv(), 32'(e));
    end
    nxt();
    bus.req0_i = 1'b0;
    @(negedge clk);
`ifdef ARB_BURST_LIMIT_EN
    chk("bl_drop", gv(), 2);
`else
    chk("bl_drop", gv(), 1);
`endif
    nxt();
    @(negedge clk);
    chk("bl_after", gv(), 2);

    // async reset mid-burst on channel 1, prio previously 1
    do_reset();
    bus.req0_i  = 1'b1;
    bus.last0_i = 1'b1;
    bus.ready_i = 1'b1;
    nxt();
    nxt();
    bus.req0_i  = 1'b0;
    bus.last0_i = 1'b0;
    bus.req1_i  = 1'b1;
    nxt();
    @(negedge clk);
    chk("ar_gnt1", gv(), 2);
    nxt();
    bus.req0_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("ar_gnt_now", gv(), 0);
    chk("ar_valid_now", bus.valid_o, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", gv(), 0);
    nxt();
    @(negedge clk);
    chk("ar_gnt0", gv(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
